seq_mult_ctrl: RTL and testbench

// - Iterative shift-and-add multiplier controller. Sequences one shared external WIDTH-bit adder
//   (our generate/propagate carry-lookahead adder) over WIDTH cycles to form a 2*WIDTH product.
// - Sits between the multiplier top level and the adder datapath. Owns operand registers,

---
 rtl/seq_mult_ctrl.sv | 140 ++++++++++++++
 tb/tb_seq_mult_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_mult_ctrl                                                 |
// | Purpose  : Iterative shift-and-add multiplier controller. Drives one     |
// |            shared external WIDTH-bit adder for WIDTH iterations to form  |
// |            a 2*WIDTH-bit unsigned product, with a start/done handshake.  |
// | Options  : APPROX_TRUNC_EN - when defined, the partial products of the   |
// |            TRUNC_BITS least significant multiplier bits are dropped      |
// |            (approximate mode, latency unchanged).                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_mult_ctrl #(
  parameter int WIDTH      = 8,
  parameter int TRUNC_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 add_en,
  output logic [WIDTH-1:0]     add_op_a,
  output logic [WIDTH-1:0]     add_op_b,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  // Counter only has to reach WIDTH-1; wraps naturally afterwards.
  localparam int               CNT_W      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef APPROX_TRUNC_EN
  localparam bit c_TRUNC_ON = 1'b1;
`else
  localparam bit c_TRUNC_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_d;

  logic [31:0]        w_cnt_ext;
  logic               w_pp_keep;
  logic               w_carry;
  logic [WIDTH-1:0]   w_sum;

  // In approximate mode the first TRUNC_BITS iterations never add; in exact
  // mode every iteration may add.
  assign w_cnt_ext = 32'(cnt_q);
  assign w_pp_keep = !c_TRUNC_ON || (w_cnt_ext >= 32'(TRUNC_BITS));

  // The adder is only engaged while iterating on a set multiplier bit, so
  // operand B is held at zero otherwise to keep the adder quiet.
  assign add_en   = (state_q == ST_ITER) && acc_lo_q[0] && w_pp_keep;
  assign add_op_a = acc_hi_q;
  assign add_op_b = add_en ? a_q : '0;

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

  // Select adder result or pass-through, then shift {carry,sum,acc_lo} right by one.
  always_comb begin
    w_carry = 1'b0;
    w_sum   = acc_hi_q;
    if (add_en) begin
      w_carry = add_cout;
      w_sum   = add_sum;
    end
    acc_hi_d = {w_carry, w_sum[WIDTH-1:1]};
    acc_lo_d = {w_sum[0], acc_lo_q[WIDTH-1:1]};
  end

  // Control FSM with registered handshake outputs and accumulator update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            acc_hi_q <= '0;
            acc_lo_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_ITER;
          end
        end
        ST_ITER: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == c_CNT_LAST) begin
            product_q <= {acc_hi_d, acc_lo_d};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_mult_ctrl                                              |
// | Purpose  : Self-checking bench for seq_mult_ctrl: vector table, hand     |
// |            sequences for multi-cycle corners, random ops vs a model.    |
// |            Honours APPROX_TRUNC_EN in its expectations.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_mult_ctrl;

  localparam int W  = 8;
  localparam int TB = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a     = '0;
  logic [W-1:0]   b     = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           add_en;
  logic [W-1:0]   add_op_a;
  logic [W-1:0]   add_op_b;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  int n_checks = 0;
  int n_err    = 0;

  seq_mult_ctrl #(
    .WIDTH      (W),
    .TRUNC_BITS (TB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_en   (add_en),
    .add_op_a (add_op_a),
    .add_op_b (add_op_b),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Behavioural stand-in for the external adder.
  assign {add_cout, add_sum} = {1'b0, add_op_a} + {1'b0, add_op_b};

  always #5 clk = ~clk;

  // Reference product from plain arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] ym;
    ym = y;
`ifdef APPROX_TRUNC_EN
    ym = y & ~W'((1 << TB) - 1);
`endif
    return {{W{1'b0}}, x} * {{W{1'b0}}, ym};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One full operation observed over a fixed window of W+2 cycles.
  // en_rule: 0 none, 1 add_en must never assert, 2 a carry-out must be used.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic [2*W-1:0] exp, input int restart_at,
                        input int en_rule, input string name);
    int busy_cnt;
    int done_cnt;
    int done_at;
    int en_cnt;
    int cout_cnt;
    logic [2*W-1:0] prod_at_done;
    busy_cnt = 0; done_cnt = 0; done_at = -1; en_cnt = 0; cout_cnt = 0;
    prod_at_done = '0;
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at      = k;
          prod_at_done = product;
        end
      end
      if (add_en) en_cnt++;
      if (add_en && add_cout) cout_cnt++;
      if (k == W + 1) begin
        check({name, ".add_en_done"}, 64'(add_en), 64'(0));
        check({name, ".op_b_done"}, 64'(add_op_b), 64'(0));
      end
      start = (restart_at != 0) && (k == restart_at);
      a = W'($urandom);
      b = W'($urandom);
    end
    check({name, ".latency"}, 64'(done_at), 64'(W + 1));
    check({name, ".done_cnt"}, 64'(done_cnt), 64'(1));
    check({name, ".busy_cnt"}, 64'(busy_cnt), 64'(W));
    check({name, ".product"}, 64'(prod_at_done), 64'(exp));
    check({name, ".held"}, 64'(product), 64'(exp));
    check({name, ".idle_busy"}, 64'(busy), 64'(0));
    if (en_rule == 1) check({name, ".no_add"}, 64'(en_cnt), 64'(0));
    if (en_rule == 2) check({name, ".carry_seen"}, 64'(cout_cnt > 0), 64'(1));
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    int             rule;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int busy_cnt;
    int done_cnt;
    int first_done;
    int second_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

`ifdef APPROX_TRUNC_EN
    vecs[0] = '{a: 8'd255, b: 8'd15,  exp: 16'd0,     rule: 1};
    vecs[1] = '{a: 8'd255, b: 8'd16,  exp: 16'd4080,  rule: 0};
    vecs[2] = '{a: 8'd255, b: 8'd31,  exp: 16'd4080,  rule: 0};
    vecs[3] = '{a: 8'd0,   b: 8'd200, exp: 16'd0,     rule: 0};
    vecs[4] = '{a: 8'd200, b: 8'd0,   exp: 16'd0,     rule: 1};
    vecs[5] = '{a: 8'd255, b: 8'd255, exp: 16'd61200, rule: 0};
`else
    vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143,   rule: 0};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'd65025, rule: 2};
    vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0,     rule: 0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   exp: 16'd0,     rule: 1};
    vecs[4] = '{a: 8'd1,   b: 8'd128, exp: 16'd128,   rule: 0};
    vecs[5] = '{a: 8'd128, b: 8'd255, exp: 16'd32640, rule: 0};
`endif

    // Reset state
    #2;
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.product", 64'(product), 64'(0));
    check("rst.add_en", 64'(add_en), 64'(0));
    check("rst.op_a", 64'(add_op_a), 64'(0));
    check("rst.op_b", 64'(add_op_b), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, applied back-to-back
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0, vecs[i].rule, $sformatf("vec%0d", i));

    // start pulsed mid-iteration must be ignored
    run_op(8'd13, 8'd11, model(8'd13, 8'd11), 3, 0, "midstart");

    // start held high: accepted only on IDLE cycles, every W+2 edges
    busy_cnt = 0; done_cnt = 0; first_done = -1; second_done = -1;
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    for (int k = 1; k <= 2 * (W + 2); k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
    end
    start = 1'b0;
    check("hold.done_cnt", 64'(done_cnt), 64'(2));
    check("hold.busy_cnt", 64'(busy_cnt), 64'(2 * W));
    check("hold.first_done", 64'(first_done), 64'(W + 1));
    check("hold.second_done", 64'(second_done), 64'(2 * W + 3));
    repeat (W + 2) @(negedge clk);
    check("hold.product", 64'(product), 64'(model(8'd3, 8'd5)));

    // Asynchronous reset in the middle of iteration 4
    @(negedge clk);
    a = 8'd13; b = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(busy), 64'(0));
    check("midrst.done", 64'(done), 64'(0));
    check("midrst.product", 64'(product), 64'(0));
    check("midrst.add_en", 64'(add_en), 64'(0));
    check("midrst.op_a", 64'(add_op_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("midrst.no_done", 64'(done_cnt), 64'(0));
    run_op(8'd200, 8'd3, model(8'd200, 8'd3), 0, 0, "postrst");

    // Random operations against the model
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, model(ra, rb), 0, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
